// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round controller: arms the random delay, lights GO,
// measures press latency in ms ticks and flags false starts and timeouts.
module reaction_round_ctrl #(
    parameter int TIME_W   = 14,
    parameter int TICK_DIV = 1000,
    parameter int MAX_TIME = 9999
) (
    input  logic              ClockIn,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              Button,
    input  logic              DelayDone,
    output logic              DelayEnable,
    output logic              Led,
    output logic [TIME_W-1:0] TimeMs,
    output logic              Valid,
    output logic              FalseStart,
    output logic              Timeout
);

    // state | meaning
    // IDLE  | after reset, waiting for the first start
    // ARMED | delay counter enabled, waiting for its done
    // GO    | light on, counting ms until press or saturation
    // DONE  | result final (press or timeout), waiting for start
    // FOUL  | pressed before the light, waiting for start
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_GO, S_DONE, S_FOUL} state_t;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t             state;
    logic [2:0]         start_sh;
    logic [2:0]         button_sh;
    logic               start_ev;
    logic               button_ev;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               arm;

    // [0],[1] form the synchronizer, [2] holds the previous synchronized level
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            start_sh  <= '0;
            button_sh <= '0;
            start_ev  <= 1'b0;
            button_ev <= 1'b0;
        end else begin
            start_sh  <= {start_sh[1:0], Start};
            button_sh <= {button_sh[1:0], Button};
            start_ev  <= start_sh[1] & ~start_sh[2];
            button_ev <= button_sh[1] & ~button_sh[2];
        end
    end

    assign tick = (presc == PRESC_W'(TICK_DIV - 1));
    assign arm  = start_ev && (state == S_IDLE || state == S_DONE || state == S_FOUL);

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            state       <= S_IDLE;
            presc       <= '0;
            DelayEnable <= 1'b0;
            Led         <= 1'b0;
            TimeMs      <= '0;
            Valid       <= 1'b0;
            FalseStart  <= 1'b0;
            Timeout     <= 1'b0;
        end else if (arm) begin
            state       <= S_ARMED;
            DelayEnable <= 1'b1;
            Led         <= 1'b0;
            TimeMs      <= '0;
            Valid       <= 1'b0;
            FalseStart  <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            case (state)
                S_ARMED: begin
                    if (button_ev) begin
                        state       <= S_FOUL;
                        DelayEnable <= 1'b0;
                        FalseStart  <= 1'b1;
                    end else if (DelayDone) begin
                        state       <= S_GO;
                        DelayEnable <= 1'b0;
                        Led         <= 1'b1;
                        presc       <= '0;
                    end
                end
                S_GO: begin
                    presc <= tick ? '0 : presc + PRESC_W'(1);
                    // a press in the same cycle as a tick keeps the pre-tick time
                    if (button_ev) begin
                        state <= S_DONE;
                        Led   <= 1'b0;
                        Valid <= 1'b1;
                    end else if (tick) begin
                        TimeMs <= TimeMs + TIME_W'(1);
                        if (TimeMs == TIME_W'(MAX_TIME - 1)) begin
                            state   <= S_DONE;
                            Led     <= 1'b0;
                            Valid   <= 1'b1;
                            Timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: two instances share stimulus, one with
// a 4-cycle tick, one with a 2-cycle tick and MAX_TIME=5 for saturation.
module tb_reaction_round_ctrl;

    logic        ClockIn;
    logic        ResetN;
    logic        Start;
    logic        Button;
    logic        DelayDone;

    logic        a_de, a_led, a_valid, a_fs, a_to;
    logic [13:0] a_time;
    logic        b_de, b_led, b_valid, b_fs, b_to;
    logic [13:0] b_time;

    int checks = 0;
    int errors = 0;

    reaction_round_ctrl #(.TIME_W(14), .TICK_DIV(4), .MAX_TIME(9999)) dut_a (
        .ClockIn(ClockIn), .ResetN(ResetN), .Start(Start), .Button(Button),
        .DelayDone(DelayDone), .DelayEnable(a_de), .Led(a_led), .TimeMs(a_time),
        .Valid(a_valid), .FalseStart(a_fs), .Timeout(a_to)
    );

    reaction_round_ctrl #(.TIME_W(14), .TICK_DIV(2), .MAX_TIME(5)) dut_b (
        .ClockIn(ClockIn), .ResetN(ResetN), .Start(Start), .Button(Button),
        .DelayDone(DelayDone), .DelayEnable(b_de), .Led(b_led), .TimeMs(b_time),
        .Valid(b_valid), .FalseStart(b_fs), .Timeout(b_to)
    );

    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge ClockIn);
    endtask

    initial begin
        ResetN    = 1'b0;
        Start     = 1'b0;
        Button    = 1'b0;
        DelayDone = 1'b0;
        step(2);
        chk("rst_a_de", 32'(a_de), 0);
        chk("rst_a_led", 32'(a_led), 0);
        chk("rst_a_time", 32'(a_time), 0);
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_a_fs", 32'(a_fs), 0);
        chk("rst_b_to", 32'(b_to), 0);
        ResetN = 1'b1;
        step(2);

        // start edge reaches the FSM output on the 4th edge
        Start = 1'b1;
        step(3);
        chk("arm_de_early", 32'(a_de), 0);
        step(1);
        chk("arm_de", 32'(a_de), 1);
        chk("arm_led", 32'(a_led), 0);
        chk("arm_valid", 32'(a_valid), 0);
        Start = 1'b0;
        step(2);
        Start = 1'b1;
        step(5);
        chk("restart_ignored_de", 32'(a_de), 1);
        chk("restart_ignored_led", 32'(a_led), 0);
        Start = 1'b0;

        // GO entry, b saturates after 10 GO cycles, a is pressed on a tick at 3
        DelayDone = 1'b1;
        step(1);
        DelayDone = 1'b0;
        chk("go_a_led", 32'(a_led), 1);
        chk("go_a_de", 32'(a_de), 0);
        chk("go_b_led", 32'(b_led), 1);
        step(9);
        chk("b_time_pre", 32'(b_time), 4);
        chk("b_led_pre", 32'(b_led), 1);
        chk("b_to_pre", 32'(b_to), 0);
        step(1);
        chk("b_time_sat", 32'(b_time), 5);
        chk("b_timeout", 32'(b_to), 1);
        chk("b_valid", 32'(b_valid), 1);
        chk("b_led_off", 32'(b_led), 0);
        step(2);
        chk("b_time_hold", 32'(b_time), 5);
        chk("a_time_12", 32'(a_time), 3);
        Button = 1'b1;
        step(3);
        chk("a_led_before_press", 32'(a_led), 1);
        chk("a_valid_before_press", 32'(a_valid), 0);
        step(1);
        chk("tick_press_time", 32'(a_time), 3);
        chk("tick_press_valid", 32'(a_valid), 1);
        chk("tick_press_led", 32'(a_led), 0);
        chk("tick_press_to", 32'(a_to), 0);
        Button = 1'b0;

        // second round: press 40 cycles after the light
        Start = 1'b1;
        step(4);
        Start = 1'b0;
        chk("rearm_de", 32'(a_de), 1);
        chk("rearm_valid", 32'(a_valid), 0);
        chk("rearm_time", 32'(a_time), 0);
        chk("rearm_b_to", 32'(b_to), 0);
        DelayDone = 1'b1;
        step(1);
        DelayDone = 1'b0;
        chk("r2_led", 32'(a_led), 1);
        step(40);
        Button = 1'b1;
        step(3);
        chk("r2_led_pre", 32'(a_led), 1);
        chk("r2_time_pre", 32'(a_time), 10);
        step(1);
        chk("r2_valid", 32'(a_valid), 1);
        chk("r2_time", 32'(a_time), 10);
        chk("r2_led_off", 32'(a_led), 0);
        Button = 1'b0;

        // false start with DelayDone in the same cycle as the button event
        Start = 1'b1;
        step(4);
        Start = 1'b0;
        Button = 1'b1;
        step(3);
        DelayDone = 1'b1;
        step(1);
        DelayDone = 1'b0;
        chk("foul_fs", 32'(a_fs), 1);
        chk("foul_led", 32'(a_led), 0);
        chk("foul_de", 32'(a_de), 0);
        chk("foul_valid", 32'(a_valid), 0);
        chk("foul_time", 32'(a_time), 0);
        chk("foul_b_fs", 32'(b_fs), 1);
        DelayDone = 1'b1;
        step(3);
        DelayDone = 1'b0;
        chk("foul_led_stays", 32'(a_led), 0);
        chk("foul_fs_held", 32'(a_fs), 1);
        Button = 1'b0;

        // asynchronous reset in the middle of GO
        Start = 1'b1;
        step(4);
        Start = 1'b0;
        DelayDone = 1'b1;
        step(1);
        DelayDone = 1'b0;
        chk("r4_led", 32'(a_led), 1);
        step(3);
        chk("r4_b_time", 32'(b_time), 1);
        #2 ResetN = 1'b0;
        #1;
        chk("async_a_led", 32'(a_led), 0);
        chk("async_a_de", 32'(a_de), 0);
        chk("async_b_led", 32'(b_led), 0);
        chk("async_b_time", 32'(b_time), 0);
        Button = 1'b1;
        @(negedge ClockIn);
        ResetN = 1'b1;
        step(6);
        Start = 1'b1;
        step(4);
        Start = 1'b0;
        chk("held_btn_de", 32'(a_de), 1);
        chk("held_btn_fs", 32'(a_fs), 0);
        step(6);
        chk("held_btn_fs_late", 32'(a_fs), 0);
        chk("held_btn_de_late", 32'(a_de), 1);
        Button = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
